// File: rtl/param_line_buffer.sv
// rtl/param_line_buffer.sv - multi-line delay chain with line-spaced taps, column tracking and fill status
// Taps are spaced in accepted samples, not clock cycles, so stalls never skew the window.
module param_line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_LEN   = 32,
    parameter int NUM_TAPS   = 3,
    localparam int CW        = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           Enable,
    input  logic                           Clear,
    input  logic [DATA_WIDTH-1:0]          DataIn,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] TapOut,
    output logic [CW-1:0]                  Col,
    output logic                           LineEnd,
    output logic                           Primed
);

    localparam int DEPTH = (NUM_TAPS - 1) * LINE_LEN + 1;
    localparam int FW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_COL = CW'(LINE_LEN - 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    logic [DATA_WIDTH-1:0] chain [DEPTH];
    logic [CW-1:0]         col_q;
    logic [FW-1:0]         fill_q;
    logic                  line_end_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) chain[i] <= '0;
            col_q      <= '0;
            fill_q     <= '0;
            line_end_q <= 1'b0;
        end else if (Clear) begin
            // Clear wins over Enable; the sample offered this cycle is dropped.
            for (int i = 0; i < DEPTH; i++) chain[i] <= '0;
            col_q      <= '0;
            fill_q     <= '0;
            line_end_q <= 1'b0;
        end else begin
            line_end_q <= Enable && (col_q == LAST_COL);
            if (Enable) begin
                chain[0] <= DataIn;
                for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
                col_q <= (col_q == LAST_COL) ? '0 : col_q + CW'(1);
                if (fill_q != FILL_MAX) fill_q <= fill_q + FW'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        assign TapOut[k*DATA_WIDTH +: DATA_WIDTH] = chain[k*LINE_LEN];
    end

    assign Col     = col_q;
    assign LineEnd = line_end_q;
    assign Primed  = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_param_line_buffer.sv
// tb/tb_param_line_buffer.sv - scoreboard bench for param_line_buffer against a sample-history model
module tb_param_line_buffer;

    localparam int DW    = 8;
    localparam int L     = 4;
    localparam int NT    = 3;
    localparam int DEPTH = (NT - 1) * L + 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             Enable = 1'b0;
    logic             Clear = 1'b0;
    logic [DW-1:0]    DataIn = '0;
    logic [NT*DW-1:0] TapOut;
    logic [1:0]       Col;
    logic             LineEnd;
    logic             Primed;

    param_line_buffer #(.DATA_WIDTH(DW), .LINE_LEN(L), .NUM_TAPS(NT)) dut (
        .CLK(CLK), .RST(RST), .Enable(Enable), .Clear(Clear), .DataIn(DataIn),
        .TapOut(TapOut), .Col(Col), .LineEnd(LineEnd), .Primed(Primed)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NT*DW-1:0] taps;
        logic [1:0]       col;
        logic             le;
        logic             pr;
    } exp_t;

    exp_t          sb [$];
    exp_t          mon_e;
    logic [DW-1:0] hist [$];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: taps read straight from the list of samples accepted since the last flush.
    task automatic model_step(input logic en, input logic clr, input logic [DW-1:0] d);
        exp_t e;
        int   idx;
        e.le = 1'b0;
        if (clr) hist.delete();
        else if (en) begin
            e.le = ((hist.size() % L) == L - 1);
            hist.push_back(d);
        end
        e.taps = '0;
        for (int k = 0; k < NT; k++) begin
            idx = hist.size() - 1 - k * L;
            if (idx >= 0) e.taps[k*DW +: DW] = hist[idx];
        end
        e.col = 2'(hist.size() % L);
        e.pr  = (hist.size() >= DEPTH);
        sb.push_back(e);
    endtask

    task automatic step(input logic en, input logic clr, input logic [DW-1:0] d);
        @(negedge CLK);
        #1;
        Enable = en;
        Clear  = clr;
        DataIn = d;
        @(posedge CLK);
        #1;
        model_step(en, clr, d);
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("sb_tap", 32'(TapOut), 32'(mon_e.taps));
            chk("sb_col", 32'(Col), 32'(mon_e.col));
            chk("sb_lineend", 32'(LineEnd), 32'(mon_e.le));
            chk("sb_primed", 32'(Primed), 32'(mon_e.pr));
        end
    end

    task automatic fill_1_to_9();
        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 1'b0, DW'(i));
            if (i == 8) chk("primed_before_full", 32'(Primed), 32'd0);
        end
        chk("fill_taps", 32'(TapOut), 32'h010509);
        chk("fill_col", 32'(Col), 32'd1);
        chk("fill_primed", 32'(Primed), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_taps", 32'(TapOut), 32'd0);
        chk("rst_col", 32'(Col), 32'd0);
        chk("rst_primed", 32'(Primed), 32'd0);
        chk("rst_lineend", 32'(LineEnd), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        fill_1_to_9();
        for (int i = 10; i <= 12; i++) step(1'b1, 1'b0, DW'(i));
        chk("stream_taps", 32'(TapOut), 32'h04080C);
        chk("stream_primed", 32'(Primed), 32'd1);

        step(1'b1, 1'b1, 8'hAA);
        chk("clear_taps", 32'(TapOut), 32'd0);
        chk("clear_col", 32'(Col), 32'd0);
        chk("clear_primed", 32'(Primed), 32'd0);

        for (int i = 1; i <= 9; i++) begin
            step(1'b1, 1'b0, DW'(i));
            step(1'b0, 1'b0, 8'hFF);
        end
        chk("gap_taps", 32'(TapOut), 32'h010509);

        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("async_taps", 32'(TapOut), 32'd0);
        chk("async_col", 32'(Col), 32'd0);
        chk("async_primed", 32'(Primed), 32'd0);
        chk("async_lineend", 32'(LineEnd), 32'd0);
        hist.delete();
        @(negedge CLK);
        RST = 1'b0;
        fill_1_to_9();

        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4, DW'($urandom));

        @(negedge CLK);
        Enable = 1'b0;
        Clear  = 1'b0;
        for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge CLK);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_line_buffer.md
PARAM_LINE_BUFFER -- requirements
Module: param_line_buffer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the bits per sample.
REQ-002 The module SHALL have parameter LINE_LEN, default 32, giving the samples per line (cells per line delay); legal range >= 2.
REQ-003 The module SHALL have parameter NUM_TAPS, default 3, giving the number of line-spaced output taps; legal range >= 2.
REQ-004 The module SHALL have local parameter CW = max(1, clog2(LINE_LEN)) and DEPTH = (NUM_TAPS-1)*LINE_LEN+1.
REQ-005 The module SHALL have these ports (name, direction, width, meaning):
- CLK  input  1  single clock, all state on rising edge
- RST  input  1  asynchronous, active-high reset
- Enable  input  1  shift strobe; one sample accepted per high cycle
- Clear  input  1  synchronous flush
- DataIn  input  DATA_WIDTH  incoming sample
- TapOut  output  NUM_TAPS*DATA_WIDTH  tap k on bits [k*DATA_WIDTH +: DATA_WIDTH]
- Col  output  CW  column index the next accepted sample will take
- LineEnd  output  1  registered pulse, last column of a line accepted
- Primed  output  1  all taps hold accepted data

Function
REQ-006 The block SHALL hold a shift chain S[0..DEPTH-1] of DATA_WIDTH registers.
REQ-007 On a cycle with Enable=1 and Clear=0, S[0] SHALL load DataIn and S[i] SHALL load S[i-1] for i >= 1, all in the same edge.
REQ-008 With Enable=0 and Clear=0, the chain, Col, fill count and Primed SHALL hold their values.
REQ-009 Tap k SHALL be driven combinationally from S[k*LINE_LEN]:
- tap 0 shows a sample 1 cycle after it is accepted;
- tap k equals the sample accepted k*LINE_LEN enables before tap 0's sample.
REQ-010 Col SHALL increment by 1 per accepted sample and wrap from LINE_LEN-1 to 0, including for non-power-of-two LINE_LEN.
REQ-011 LineEnd SHALL be registered as (Enable & ~Clear & Col==LINE_LEN-1), so it is high for exactly the cycle after that edge.
REQ-012 A fill counter SHALL count accepted samples, saturating at DEPTH.
REQ-013 Primed SHALL be high exactly when the fill counter equals DEPTH; once set it SHALL stay high until Clear or RST.
REQ-014 Clear=1 SHALL, on the next edge, zero S[], Col, the fill counter, Primed and LineEnd.
REQ-015 Clear SHALL take priority over a simultaneous Enable, and the sample presented in that cycle SHALL be discarded.
REQ-016 Gaps in Enable SHALL NOT alter tap spacing, which is counted in accepted samples, not clock cycles.
REQ-017 The DataIn value SHALL be ignored when Enable=0.

Reset
REQ-018 RST=1 SHALL asynchronously force S[] to 0, TapOut to 0, Col to 0, fill counter to 0, LineEnd to 0 and Primed to 0, independent of CLK.
REQ-019 After RST deasserts, the first accepted sample SHALL take column 0.
REQ-020 Asserting RST mid-stream SHALL discard all buffered data, with no partial state retained.

Verification (DATA_WIDTH=8, LINE_LEN=4, NUM_TAPS=3, DEPTH=9)
REQ-021 Fill: after reset, Enable high for 9 cycles with DataIn 1..9 -> Primed rises after the 9th edge, TapOut = {8'd1, 8'd5, 8'd9}, Col = 1.
REQ-022 Steady stream: continue with DataIn 10..12 -> after the 12th edge, TapOut = {8'd4, 8'd8, 8'd12}, Primed stays 1.
REQ-023 LineEnd and wrap: across samples 1..12 -> LineEnd high in the cycle after samples 4, 8 and 12 are accepted, low otherwise; Col sequence 0,1,2,3,0,...
REQ-024 Enable gaps: feed 1..9 with Enable toggling 1/0 and DataIn=8'hFF during low cycles -> final TapOut = {1,5,9}; 8'hFF is never seen on any tap.
REQ-025 Clear vs Enable: once Primed, assert Clear and Enable together with DataIn=8'hAA -> next cycle TapOut=0, Col=0, Primed=0; 8'hAA is not stored.
REQ-026 Async reset: assert RST between clock edges while Primed -> all outputs read 0 before the next CLK edge; refill then repeats the REQ-021 result.
